mc_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the MIPS core. It shares one memory port and one ALU across the FETCH/DECODE/EXEC/MEM/WB steps. It drives every datapath mux, write-enable and memory request from a registered state plus the latched opcode/funct, and counts retired instructions. It sits beside the datapath and takes its opcode and funct from the instruction register.

---
 rtl/mips_ctrl_pkg.sv | 92 +++++++++
 rtl/alu_op_dec.sv | 48 ++++
 rtl/mc_ctrl_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcode/funct
// constants, ALU operation codes, sequencer states, datapath select codes
// and the bundle of per-cycle control outputs.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  // ALU operations
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_ADD  = 4'b1011;
  localparam logic [3:0] ALU_SUB  = 4'b1110;
  localparam logic [3:0] ALU_INV  = 4'b1111;

  // Datapath select encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_BR   = 2'b10;
  localparam logic [1:0] SRCB_IMM  = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] WD_MEM = 2'b00;
  localparam logic [1:0] WD_ALU = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_EXEC_R,
    S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_JREG, S_TRAP
  } state_t;

  // Everything the sequencer drives combinationally in a cycle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_wren;
    logic       pc_wren;
    logic [1:0] pc_src;
    logic       alu_srca_sel;
    logic [1:0] alu_srcb_sel;
    logic       imm_zext;
    logic [3:0] alu_op;
    logic       reg_file_wren;
    logic [1:0] reg_dst_sel;
    logic [1:0] reg_wdata_sel;
  } ctrl_t;

endpackage

// File: rtl/alu_op_dec.sv
// ALU operation decoder: (opcode, funct) -> alu_op plus a legal flag.
// legal is set only for ALU-computing instructions: R-type arithmetic/logic/
// shift functs and the I-type ADDI/ADDIU/SLTI/ANDI/ORI. Everything else
// (including jumps, branches, loads/stores) reports alu_op=invalid, legal=0.
//   op, funct : instruction fields
//   alu_op    : ALU operation code
//   legal     : instruction is a recognised ALU operation
module alu_op_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_INV;
    legal  = 1'b1;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD:   alu_op = ALU_ADD;
        F_ADDU:  alu_op = ALU_ADDU;
        F_SUB:   alu_op = ALU_SUB;
        F_SUBU:  alu_op = ALU_SUBU;
        F_AND:   alu_op = ALU_AND;
        F_OR:    alu_op = ALU_OR;
        F_XOR:   alu_op = ALU_XOR;
        F_NOR:   alu_op = ALU_NOR;
        F_SLT:   alu_op = ALU_SLT;
        F_SLL:   alu_op = ALU_SLL;
        F_SRL:   alu_op = ALU_SRL;
        F_SRA:   alu_op = ALU_SRA;
        default: legal  = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI:  alu_op = ALU_ADD;
        OP_ADDIU: alu_op = ALU_ADDU;
        OP_SLTI:  alu_op = ALU_SLT;
        OP_ANDI:  alu_op = ALU_AND;
        OP_ORI:   alu_op = ALU_OR;
        default:  legal  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer. Steps one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB sharing one memory port and one ALU; all datapath
// controls are decoded combinationally from the registered state, the IR
// opcode/funct, mem_ready and alu_zf. Counts retired instructions and traps
// (sticky) on unrecognised instructions.
//   clk, rst            : clock, synchronous active-high reset
//   instr_op/funct      : IR fields
//   alu_zf, mem_ready   : ALU zero flag, memory acknowledge
//   mem_*               : memory request / write / address source
//   ir_wren, pc_*       : IR load, PC load and next-PC source
//   alu_*, imm_zext     : ALU operand sources, operation, immediate extension
//   reg_*               : register-file write enable, destination, data source
//   illegal_instr       : sticky trap flag
//   retired_cnt         : completed-instruction count (wraps)
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH,
  parameter int     CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instr_op,
  input  logic [5:0]       instr_funct,
  input  logic             alu_zf,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_wren,
  output logic             pc_wren,
  output logic [1:0]       pc_src,
  output logic             alu_srca_sel,
  output logic [1:0]       alu_srcb_sel,
  output logic             imm_zext,
  output logic [3:0]       alu_op,
  output logic             reg_file_wren,
  output logic [1:0]       reg_dst_sel,
  output logic [1:0]       reg_wdata_sel,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t     state, nxt;
  ctrl_t      c, co;
  logic [3:0] dec_op;
  logic       dec_legal;
  logic       is_r, br_take;

  alu_op_dec u_dec (
    .op     (instr_op),
    .funct  (instr_funct),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  assign is_r    = (instr_op == OP_RTYPE);
  assign br_take = ((instr_op == OP_BEQ) &&  alu_zf) ||
                   ((instr_op == OP_BNE) && !alu_zf);

  always_comb begin
    c   = '0;
    nxt = state;
    case (state)
      S_FETCH: begin
        c.mem_req      = 1'b1;
        c.alu_srcb_sel = SRCB_4;
        c.alu_op       = ALU_ADDU;
        c.pc_src       = PCSRC_ALU;
        if (mem_ready) begin
          c.ir_wren = 1'b1;
          c.pc_wren = 1'b1;
          nxt       = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        c.alu_srcb_sel = SRCB_BR;
        c.alu_op       = ALU_ADDU;
        if (instr_op == OP_J || instr_op == OP_JAL)
          nxt = S_JUMP;
        else if (is_r && (instr_funct == F_JR || instr_funct == F_JALR))
          nxt = S_JREG;
        else if (instr_op == OP_LW || instr_op == OP_SW)
          nxt = S_MEM_ADDR;
        else if (dec_legal)
          nxt = is_r ? S_EXEC_R : S_EXEC_I;
        else if (instr_op == OP_BEQ || instr_op == OP_BNE)
          nxt = S_BRANCH;
        else
          nxt = S_TRAP;
      end
      S_MEM_ADDR: begin
        c.alu_srca_sel = 1'b1;
        c.alu_srcb_sel = SRCB_IMM;
        c.alu_op       = ALU_ADD;
        nxt            = (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.mem_req      = 1'b1;
        c.mem_addr_sel = 1'b1;
        if (mem_ready) nxt = S_LW_WB;
      end
      S_LW_WB: begin
        c.reg_file_wren = 1'b1;
        c.reg_dst_sel   = DST_RT;
        c.reg_wdata_sel = WD_MEM;
        nxt             = S_FETCH;
      end
      S_MEM_WR: begin
        c.mem_req      = 1'b1;
        c.mem_we       = 1'b1;
        c.mem_addr_sel = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_EXEC_R: begin
        c.alu_srca_sel = 1'b1;
        c.alu_srcb_sel = SRCB_REGB;
        c.alu_op       = dec_op;
        nxt            = S_R_WB;
      end
      S_R_WB: begin
        c.reg_file_wren = 1'b1;
        c.reg_dst_sel   = DST_RD;
        c.reg_wdata_sel = WD_ALU;
        nxt             = S_FETCH;
      end
      S_EXEC_I: begin
        c.alu_srca_sel = 1'b1;
        c.alu_srcb_sel = SRCB_IMM;
        c.imm_zext     = (instr_op == OP_ANDI) || (instr_op == OP_ORI);
        c.alu_op       = dec_op;
        nxt            = S_I_WB;
      end
      S_I_WB: begin
        c.reg_file_wren = 1'b1;
        c.reg_dst_sel   = DST_RT;
        c.reg_wdata_sel = WD_ALU;
        nxt             = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_srca_sel = 1'b1;
        c.alu_srcb_sel = SRCB_REGB;
        c.alu_op       = ALU_SUB;
        c.pc_wren      = br_take;
        c.pc_src       = br_take ? PCSRC_ALUOUT : PCSRC_ALU;
        nxt            = S_FETCH;
      end
      S_JUMP: begin
        c.pc_wren = 1'b1;
        c.pc_src  = PCSRC_JUMP;
        if (instr_op == OP_JAL) begin
          c.reg_file_wren = 1'b1;
          c.reg_dst_sel   = DST_R31;
          c.reg_wdata_sel = WD_PC;
        end
        nxt = S_FETCH;
      end
      S_JREG: begin
        c.pc_wren = 1'b1;
        c.pc_src  = PCSRC_REGA;
        if (instr_funct == F_JALR) begin
          c.reg_file_wren = 1'b1;
          c.reg_dst_sel   = DST_RD;
          c.reg_wdata_sel = WD_PC;
        end
        nxt = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

  // Reset kills any in-flight request in the same cycle it is asserted.
  assign co = rst ? '0 : c;

  assign mem_req       = co.mem_req;
  assign mem_we        = co.mem_we;
  assign mem_addr_sel  = co.mem_addr_sel;
  assign ir_wren       = co.ir_wren;
  assign pc_wren       = co.pc_wren;
  assign pc_src        = co.pc_src;
  assign alu_srca_sel  = co.alu_srca_sel;
  assign alu_srcb_sel  = co.alu_srcb_sel;
  assign imm_zext      = co.imm_zext;
  assign alu_op        = co.alu_op;
  assign reg_file_wren = co.reg_file_wren;
  assign reg_dst_sel   = co.reg_dst_sel;
  assign reg_wdata_sel = co.reg_wdata_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_STATE;
      retired_cnt   <= '0;
      illegal_instr <= 1'b0;
    end else begin
      state <= nxt;
      // FETCH->FETCH is a memory wait, not a completion.
      if (nxt == S_FETCH && state != S_FETCH)
        retired_cnt <= retired_cnt + CNT_W'(1);
      if (nxt == S_TRAP)
        illegal_instr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_wren;
    logic       pc_wren;
    logic [1:0] pc_src;
    logic       srca;
    logic [1:0] srcb;
    logic       imm_zext;
    logic [3:0] alu_op;
    logic       wren;
    logic [1:0] dst;
    logic [1:0] wdata;
    logic       ill;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  instr_op, instr_funct;
  logic        alu_zf, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_wren, pc_wren;
  logic [1:0]  pc_src, alu_srcb_sel, reg_dst_sel, reg_wdata_sel;
  logic        alu_srca_sel, imm_zext, reg_file_wren, illegal_instr;
  logic [3:0]  alu_op;
  logic [31:0] retired_cnt;

  out_t        act;
  out_t        exp_q[$];
  logic [31:0] cnt_q[$];
  logic [31:0] exp_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .instr_funct(instr_funct),
    .alu_zf(alu_zf), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_wren(ir_wren), .pc_wren(pc_wren),
    .pc_src(pc_src), .alu_srca_sel(alu_srca_sel), .alu_srcb_sel(alu_srcb_sel),
    .imm_zext(imm_zext), .alu_op(alu_op), .reg_file_wren(reg_file_wren),
    .reg_dst_sel(reg_dst_sel), .reg_wdata_sel(reg_wdata_sel),
    .illegal_instr(illegal_instr), .retired_cnt(retired_cnt)
  );

  assign act = {mem_req, mem_we, mem_addr_sel, ir_wren, pc_wren, pc_src,
                alu_srca_sel, alu_srcb_sel, imm_zext, alu_op, reg_file_wren,
                reg_dst_sel, reg_wdata_sel, illegal_instr};

  function automatic out_t o_fetch(input logic rdy);
    out_t o = '0;
    o.mem_req = 1'b1; o.srcb = 2'b01; o.alu_op = 4'b0010;
    o.ir_wren = rdy;  o.pc_wren = rdy;
    return o;
  endfunction

  function automatic out_t o_decode();
    out_t o = '0;
    o.srcb = 2'b10; o.alu_op = 4'b0010;
    return o;
  endfunction

  function automatic out_t o_branch(input logic take);
    out_t o = '0;
    o.srca = 1'b1; o.srcb = 2'b00; o.alu_op = 4'b1110;
    o.pc_wren = take; o.pc_src = take ? 2'b01 : 2'b00;
    return o;
  endfunction

  function automatic out_t o_wb(input logic [1:0] dst, input logic [1:0] wd);
    out_t o = '0;
    o.wren = 1'b1; o.dst = dst; o.wdata = wd;
    return o;
  endfunction

  // Called at a falling edge with inputs already driven: queue expectation,
  // sample 1 time unit later, compare, then advance to the next falling edge.
  task automatic chk(input out_t e, input string tag);
    out_t        ge;
    logic [31:0] gc;
    exp_q.push_back(e);
    cnt_q.push_back(exp_cnt);
    #1;
    ge = exp_q.pop_front();
    gc = cnt_q.pop_front();
    checks++;
    assert (act === ge) else begin
      errors++;
      $error("FAIL %s outputs got %h exp %h", tag, act, ge);
    end
    checks++;
    assert (retired_cnt === gc) else begin
      errors++;
      $error("FAIL %s retired_cnt got %0d exp %0d", tag, retired_cnt, gc);
    end
    @(negedge clk);
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    instr_op = op; instr_funct = fn; mem_ready = 1'b1;
    chk(o_fetch(1'b1), "fetch");
    mem_ready = 1'b0;
    chk(o_decode(), "decode");
  endtask

  initial begin
    out_t o;
    rst = 1'b1; instr_op = '0; instr_funct = '0; alu_zf = 1'b0; mem_ready = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk('0, "rst0");
    chk('0, "rst1");
    rst = 1'b0;
    chk(o_fetch(1'b0), "fetch_idle");

    // ADDU
    fetch_decode(6'h00, 6'h21);
    o = '0; o.srca = 1'b1; o.alu_op = 4'b0010;
    chk(o, "addu_exec");
    chk(o_wb(2'b01, 2'b01), "addu_wb");
    exp_cnt++;

    // LW with two wait cycles in MEM_RD
    fetch_decode(6'h23, 6'h00);
    o = '0; o.srca = 1'b1; o.srcb = 2'b11; o.alu_op = 4'b1011;
    chk(o, "lw_addr");
    o = '0; o.mem_req = 1'b1; o.mem_addr_sel = 1'b1;
    chk(o, "lw_wait0");
    chk(o, "lw_wait1");
    mem_ready = 1'b1;
    chk(o, "lw_rd");
    mem_ready = 1'b0;
    chk(o_wb(2'b00, 2'b00), "lw_wb");
    exp_cnt++;

    // Branches: BEQ/BNE with both flag values
    fetch_decode(6'h04, 6'h00);
    alu_zf = 1'b1; chk(o_branch(1'b1), "beq_zf1"); exp_cnt++;
    fetch_decode(6'h04, 6'h00);
    alu_zf = 1'b0; chk(o_branch(1'b0), "beq_zf0"); exp_cnt++;
    fetch_decode(6'h05, 6'h00);
    alu_zf = 1'b1; chk(o_branch(1'b0), "bne_zf1"); exp_cnt++;
    fetch_decode(6'h05, 6'h00);
    alu_zf = 1'b0; chk(o_branch(1'b1), "bne_zf0"); exp_cnt++;

    // JAL
    fetch_decode(6'h03, 6'h00);
    o = o_wb(2'b10, 2'b10); o.pc_wren = 1'b1; o.pc_src = 2'b10;
    chk(o, "jal");
    exp_cnt++;

    // JALR
    fetch_decode(6'h00, 6'h09);
    o = o_wb(2'b01, 2'b10); o.pc_wren = 1'b1; o.pc_src = 2'b11;
    chk(o, "jalr");
    exp_cnt++;

    // ANDI: zero-extended immediate, AND
    fetch_decode(6'h0C, 6'h00);
    o = '0; o.srca = 1'b1; o.srcb = 2'b11; o.imm_zext = 1'b1; o.alu_op = 4'b0000;
    chk(o, "andi_exec");
    chk(o_wb(2'b00, 2'b01), "andi_wb");
    exp_cnt++;

    // SW interrupted by reset while waiting in MEM_WR
    fetch_decode(6'h2B, 6'h00);
    o = '0; o.srca = 1'b1; o.srcb = 2'b11; o.alu_op = 4'b1011;
    chk(o, "sw_addr");
    o = '0; o.mem_req = 1'b1; o.mem_we = 1'b1; o.mem_addr_sel = 1'b1;
    chk(o, "sw_wait");
    rst = 1'b1; mem_ready = 1'b1;
    chk('0, "sw_rst");
    exp_cnt = 0;
    rst = 1'b0; mem_ready = 1'b0;
    chk(o_fetch(1'b0), "sw_recover");

    // Illegal opcode traps; memory acknowledges are ignored
    fetch_decode(6'h3F, 6'h00);
    o = '0; o.ill = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      chk(o, "trap");
    end
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk(o_fetch(1'b0), "trap_recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
